// File: rtl/filter_ch.sv
// One debounce channel: 2-flop synchroniser, sample history with unanimous-vote
// hysteresis, and one-cycle rise/fall strobes on the filtered level.
module filter_ch #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  input  logic stb_i,
  input  logic clr_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0]       sync_q;
  logic [DEPTH-1:0] hist_q;
  logic [DEPTH-1:0] hist_d;
  logic             all_one;
  logic             all_zero;
  logic             dout_q;
  logic             rise_q;
  logic             fall_q;

  // The synchroniser free-runs; only reset touches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], din_i};
    end
  end

  always_comb begin
    hist_d   = {hist_q[DEPTH-2:0], sync_q[1]};
    all_one  = &hist_d;
    all_zero = ~|hist_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      dout_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else if (clr_i) begin
      hist_q <= '0;
      dout_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= stb_i & ~dout_q & all_one;
      fall_q <= stb_i & dout_q & all_zero;
      if (stb_i) begin
        hist_q <= hist_d;
        // Mixed history keeps the current level.
        if (all_one) begin
          dout_q <= 1'b1;
        end else if (all_zero) begin
          dout_q <= 1'b0;
        end
      end
    end
  end

  assign dout_o = dout_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/multi_ch_filter.sv
// Multi-channel debounce filter: shared sample prescaler feeding CH independent
// filter_ch instances, plus a registered copy of the sample strobe.
module multi_ch_filter #(
  parameter int unsigned CH    = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIV   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] din_i,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [CH-1:0] dout_o,
  output logic [CH-1:0] rise_o,
  output logic [CH-1:0] fall_o,
  output logic          tick_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            stb;
  logic            tick_q;

  // With DIV=1 the counter is stuck at 0 == CntMax, so stb follows en.
  assign stb = en_i & (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= stb & ~clr_i;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    filter_ch #(
      .DEPTH (DEPTH)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .din_i  (din_i[g]),
      .stb_i  (stb),
      .clr_i  (clr_i),
      .dout_o (dout_o[g]),
      .rise_o (rise_o[g]),
      .fall_o (fall_o[g])
    );
  end

  assign tick_o = tick_q;

endmodule

// File: doc/multi_ch_filter.md
# multi_ch_filter

Parametrised multi-channel debounce/glitch filter with hysteresis and edge strobes. It is the next-generation replacement for the fixed 4-bit single-channel filter. It sits between raw asynchronous inputs (buttons, switches, slow sensor lines) and control logic. Each channel is synchronised and sampled at a programmable rate into a DEPTH-bit history. The output changes only on a unanimous history.

## Interface
- CH, 4: number of independent channels (≥1)
- DEPTH, 4: history length in samples (≥2)
- DIV, 1: sample divider; one sample tick every DIV enabled cycles (≥1)

One clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- din  in  CH  raw asynchronous inputs
- en  in  1  enable; low freezes prescaler and histories
- clr  in  1  synchronous clear of histories, outputs and prescaler
- dout  out  CH  filtered level per channel
- rise  out  CH  one-cycle pulse when dout[c] goes 0→1
- fall  out  CH  one-cycle pulse when dout[c] goes 1→0
- tick  out  1  registered copy of the internal sample strobe (diagnostic)

## Operation
- Reset (rst_n low): sync flops, histories, prescaler, dout, rise, fall and tick all 0, immediately without a clock edge.
- Synchroniser: 2-flop chain per channel, always running (ignores en and clr except reset); its output is s[c].
- Prescaler: counter cnt of width max(1,clog2(DIV)).
  - When en=1, cnt increments and wraps DIV-1→0.
  - Internal strobe stb = en & (cnt==DIV-1).
  - With DIV=1, stb = en.
- On stb, per channel: h' = {hist[DEPTH-2:0], s[c]}; hist <= h'.
  - If h' is all ones: dout <= 1.
  - If h' is all zeros: dout <= 0.
  - Otherwise dout holds (hysteresis).
- rise[c] <= stb & ~dout[c] & (h' all ones); fall[c] <= stb & dout[c] & (h' all zeros). Otherwise 0, so pulses last exactly one cycle.
- tick <= stb.
- clr=1 (highest priority after reset): hist, dout, cnt ← 0; rise, fall, tick ← 0. No fall pulse is generated even if dout was 1.
- en=0: cnt, hist and dout hold; rise, fall and tick ← 0.
- Channels are fully independent; simultaneous rise on some channels and fall on others in the same cycle is legal.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Latency with DIV=1, en=1: din stable before edge k → s valid after edge k+1 → dout, rise/fall update at edge k+DEPTH+1. That is DEPTH+2 edges.
- With DIV>1: dout changes on the DEPTH-th stb edge that sampled the new synchronised value. It always coincides with a tick=1 cycle.
- A pulse on din shorter than DEPTH consecutive samples never changes dout.
- A glitch fully inside the hold band leaves dout unchanged. For example, with dout=1, any history containing a 1 keeps dout=1.
- clr and stb in the same cycle: clr wins and the history is not updated.
- Reset deassertion is synchronised by the system; no recovery logic is required here.

## Structure
- No shared package is needed. The counter width is a local constant computed from DIV; no exported typedefs.
- Sub-module filter_ch, instantiated CH times via generate. It contains the 2-flop synchroniser, the DEPTH-bit history, dout and the rise/fall registers, with inputs clk, rst_n, din, stb, clr.
- The top level holds the shared prescaler and the tick register, and concatenates the channel outputs.

## Test plan
- Reset, CH=4, DEPTH=4, DIV=1, din=4'hF held:
  - While rst_n=0: all outputs 0.
  - After release: dout=4'hF exactly 6 edges after the first clock.
  - rise=4'hF for one cycle; fall stays 0.
- Glitch: din[0] high for 3 cycles, then low. dout[0] stays 0 and no rise. Repeating with 4 cycles high gives dout[0]=1 and one rise pulse.
- Hysteresis: after dout=4'h1, toggle din[0] every cycle for 20 cycles. dout[0] stays 1 and rise/fall stay 0. Then hold din[0]=0: dout[0]=0 after 6 edges, with one fall pulse.
- DIV=3, en=1 continuous:
  - tick pulses every 3rd cycle.
  - After a din step, dout rises on a tick cycle, between 2+3·3+1 and 2+4·3 edges later.
  - Dropping en for 5 cycles delays the rise by exactly 5 cycles.
- clr: assert clr on the stb cycle that would complete all ones. dout stays 0 and no rise. Asserting clr with dout=4'hF gives dout=0 next edge with fall=0.
- Async reset mid-operation: with dout=4'hA and rise active, pull rst_n low between clock edges. All outputs read 0 before the next edge, and stay 0 until sampling restarts.
